// File: rtl/ble_packet_parser.sv
// Decodes "!B<id><0|1><chk>" BLE controller button packets from the UART byte
// stream into checksum-verified button events and a held-button register.
module ble_packet_parser #(
  parameter int TIMEOUT_CYCLES = 742500,
  parameter int CNT_W          = 20
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       evt_valid_out,
  output logic [2:0] evt_id_out,
  output logic       evt_pressed_out,
  output logic [7:0] buttons_out,
  output logic [7:0] err_count_out,
  output logic       busy_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BANG,
    S_TYPE,
    S_ID,
    S_PRESS
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [7:0]       acc, acc_next;
  logic [2:0]       id_q, id_next;
  logic             pressed_q, pressed_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, reject, timeout;

  // An incoming byte always takes priority over the idle-timeout abort.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    id_next      = id_q;
    pressed_next = pressed_q;
    accept       = 1'b0;
    reject       = 1'b0;
    timeout      = (state != S_IDLE) && !valid_in && (cnt == TIMEOUT_LAST);

    if (valid_in) begin
      case (state)
        S_IDLE: begin
          if (data_in == 8'h21) begin
            state_next = S_BANG;
            acc_next   = 8'h21;
          end
        end
        S_BANG: begin
          if (data_in == 8'h42) begin
            state_next = S_TYPE;
            acc_next   = acc + data_in;
          end else if (data_in == 8'h21) begin
            acc_next = 8'h21;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_TYPE: begin
          if (data_in >= 8'h31 && data_in <= 8'h38) begin
            state_next = S_ID;
            // Low bits of '1'..'8' are 1..7,0, so subtracting one yields 0..7.
            id_next    = data_in[2:0] - 3'd1;
            acc_next   = acc + data_in;
          end else begin
            state_next = S_IDLE;
            reject     = 1'b1;
          end
        end
        S_ID: begin
          if (data_in == 8'h30 || data_in == 8'h31) begin
            state_next   = S_PRESS;
            pressed_next = data_in[0];
            acc_next     = acc + data_in;
          end else begin
            state_next = S_IDLE;
            reject     = 1'b1;
          end
        end
        S_PRESS: begin
          state_next = S_IDLE;
          if (data_in == ~acc) accept = 1'b1;
          else                 reject = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (timeout) begin
      state_next = S_IDLE;
      reject     = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      acc             <= 8'h00;
      id_q            <= 3'd0;
      pressed_q       <= 1'b0;
      cnt             <= '0;
      evt_valid_out   <= 1'b0;
      evt_id_out      <= 3'd0;
      evt_pressed_out <= 1'b0;
      buttons_out     <= 8'h00;
      err_count_out   <= 8'h00;
      busy_out        <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      id_q      <= id_next;
      pressed_q <= pressed_next;
      busy_out  <= (state_next != S_IDLE);

      if (valid_in || timeout)  cnt <= '0;
      else if (state != S_IDLE) cnt <= cnt + 1'b1;

      evt_valid_out <= accept;
      if (accept) begin
        evt_id_out        <= id_q;
        evt_pressed_out   <= pressed_q;
        buttons_out[id_q] <= pressed_q;
      end

      if (reject && err_count_out != 8'hFF) err_count_out <= err_count_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_ble_packet_parser.sv
// Randomized self-checking bench for ble_packet_parser against a packet-level
// reference model that buffers received bytes and validates them by arithmetic.
module tb_ble_packet_parser;

  localparam int T = 16;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       evt_valid_out;
  logic [2:0] evt_id_out;
  logic       evt_pressed_out;
  logic [7:0] buttons_out;
  logic [7:0] err_count_out;
  logic       busy_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] pkt [4];
  int         plen;
  int         idle;
  bit         m_evt;
  logic [2:0] m_id;
  bit         m_pressed;
  logic [7:0] m_buttons;
  int         m_err;

  ble_packet_parser #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .data_in(data_in),
    .valid_in(valid_in),
    .evt_valid_out(evt_valid_out),
    .evt_id_out(evt_id_out),
    .evt_pressed_out(evt_pressed_out),
    .buttons_out(buttons_out),
    .err_count_out(err_count_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    plen = 0; idle = 0; m_evt = 0; m_id = 0; m_pressed = 0; m_buttons = 0; m_err = 0;
  endfunction

  function automatic void modelError();
    if (m_err < 255) m_err++;
  endfunction

  // Collects up to four header bytes, then judges the fifth against their sum.
  function automatic void modelByte(input logic [7:0] b);
    int sum;
    logic [7:0] chk;
    case (plen)
      0: if (b == 8'h21) begin pkt[0] = b; plen = 1; end
      1: begin
        if (b == 8'h42) begin pkt[1] = b; plen = 2; end
        else if (b == 8'h21) begin pkt[0] = b; plen = 1; end
        else plen = 0;
      end
      2: begin
        if (b >= 8'h31 && b <= 8'h38) begin pkt[2] = b; plen = 3; end
        else begin modelError(); plen = 0; end
      end
      3: begin
        if (b == 8'h30 || b == 8'h31) begin pkt[3] = b; plen = 4; end
        else begin modelError(); plen = 0; end
      end
      default: begin
        sum = int'(pkt[0]) + int'(pkt[1]) + int'(pkt[2]) + int'(pkt[3]);
        chk = ~(sum[7:0]);
        if (b == chk) begin
          m_id = 3'(pkt[2] - 8'h31);
          m_pressed = (pkt[3] == 8'h31);
          m_buttons[m_id] = m_pressed;
          m_evt = 1;
        end else begin
          modelError();
        end
        plen = 0;
      end
    endcase
  endfunction

  function automatic void modelStep(input bit v, input logic [7:0] b);
    m_evt = 0;
    if (v) begin
      idle = 0;
      modelByte(b);
    end else if (plen > 0) begin
      idle++;
      if (idle >= T) begin
        modelError();
        plen = 0;
        idle = 0;
      end
    end
  endfunction

  task automatic compareAll();
    checkOutput("evt_valid", 32'(evt_valid_out), 32'(m_evt));
    checkOutput("evt_id", 32'(evt_id_out), 32'(m_id));
    checkOutput("evt_pressed", 32'(evt_pressed_out), 32'(m_pressed));
    checkOutput("buttons", 32'(buttons_out), 32'(m_buttons));
    checkOutput("err_count", 32'(err_count_out), 32'(m_err));
    checkOutput("busy", 32'(busy_out), 32'(plen > 0));
  endtask

  // One clock cycle: drive at the falling edge, check just after the rising edge.
  task automatic applyStimulus(input bit v, input logic [7:0] b);
    @(negedge clk_in);
    valid_in = v;
    data_in  = v ? b : 8'($urandom);
    modelStep(v, b);
    @(posedge clk_in);
    #1;
    compareAll();
  endtask

  task automatic sendBytes(input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, seq[8*(n-1-i) +: 8]);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendRandomPacket();
    logic [7:0] p [5];
    int sum;
    int kind;
    int n;
    int gap;
    kind = int'($urandom_range(0, 9));
    p[0] = 8'h21;
    p[1] = 8'h42;
    p[2] = 8'h31 + 8'($urandom_range(0, 7));
    p[3] = 8'h30 + 8'($urandom_range(0, 1));
    sum = int'(p[0]) + int'(p[1]) + int'(p[2]) + int'(p[3]);
    p[4] = ~(sum[7:0]);
    n = 5;
    if (kind == 5) p[$urandom_range(1, 4)] = 8'($urandom);
    if (kind == 6) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < 5; i++) p[i] = 8'($urandom_range(0, 3) == 0 ? 8'h21 : $urandom);
    end
    if (kind == 7) n = int'($urandom_range(1, 4));
    if (kind == 8) p[4] = p[4] ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, p[i]);
      gap = int'($urandom_range(0, 2));
      if (kind == 9 && $urandom_range(0, 3) == 0) gap = T - 2 + int'($urandom_range(0, 3));
      idleCycles(gap);
    end
  endtask

  initial begin
    modelReset();
    #12;
    compareAll();
    @(negedge clk_in);
    rst_in = 1'b1;

    $display("[TB] directed: press / release");
    sendBytes(64'h2142353136, 5);
    checkOutput("tp_press_evt", 32'(evt_valid_out), 32'd1);
    checkOutput("tp_press_id", 32'(evt_id_out), 32'd4);
    checkOutput("tp_press_buttons", 32'(buttons_out), 32'h10);
    idleCycles(1);
    sendBytes(64'h2142353037, 5);
    checkOutput("tp_release_pressed", 32'(evt_pressed_out), 32'd0);
    checkOutput("tp_release_buttons", 32'(buttons_out), 32'h00);

    $display("[TB] directed: bad checksum, resync");
    sendBytes(64'h214231313B, 5);
    checkOutput("tp_badchk_evt", 32'(evt_valid_out), 32'd0);
    checkOutput("tp_badchk_err", 32'(err_count_out), 32'd1);
    sendBytes(64'h214231313A, 5);
    checkOutput("tp_goodchk_buttons", 32'(buttons_out), 32'h01);
    sendBytes(64'h55212142383133, 7);
    checkOutput("tp_resync_buttons", 32'(buttons_out), 32'h81);
    checkOutput("tp_resync_err", 32'(err_count_out), 32'd1);

    $display("[TB] directed: timeout");
    sendBytes(64'h2142, 2);
    idleCycles(T - 1);
    checkOutput("tp_timeout_busy_before", 32'(busy_out), 32'd1);
    idleCycles(1);
    checkOutput("tp_timeout_busy_after", 32'(busy_out), 32'd0);
    checkOutput("tp_timeout_err", 32'(err_count_out), 32'd2);
    idleCycles(4);
    sendBytes(64'h2142383034, 5);
    checkOutput("tp_after_timeout_buttons", 32'(buttons_out), 32'h01);
    sendBytes(64'h2142, 2);
    idleCycles(T - 1);
    sendBytes(64'h353136, 3);
    checkOutput("tp_byte_wins_evt", 32'(evt_valid_out), 32'd1);
    checkOutput("tp_byte_wins_err", 32'(err_count_out), 32'd2);

    $display("[TB] directed: async reset mid-packet");
    sendBytes(64'h214235, 3);
    #3;
    rst_in = 1'b0;
    valid_in = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    sendBytes(64'h3136, 2);
    idleCycles(1);

    $display("[TB] random packets");
    for (int k = 0; k < 1200; k++) sendRandomPacket();
    idleCycles(T + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ble_packet_parser.md
Name: ble_packet_parser

Overview:
- Byte-stream decoder between the BLE UART receiver and the gameplay block.
- Consumes bytes from the UART receiver (data plus a 1-cycle valid strobe) and recognises controller button packets of the form '!' 'B' <id '1'..'8'> <'1' press / '0' release> <checksum>.
- Emits checksum-verified button events and a live 8-bit button-state register to gameplay.
- Runs on the pixel clock domain.

Parameters:
- TIMEOUT_CYCLES, 742500, maximum idle cycles between bytes inside a packet before abort (10 ms at 74.25 MHz).
- CNT_W, 20, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock (pixel clock).
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  8  received byte.
- valid_in  input  1  1-cycle strobe; data_in is valid this cycle.
- evt_valid_out  output  1  1-cycle pulse; event fields valid.
- evt_id_out  output  3  button index 0..7 (ASCII '1'..'8' minus 0x31).
- evt_pressed_out  output  1  1 = press, 0 = release.
- buttons_out  output  8  current held state; bit i = button i.
- err_count_out  output  8  saturating count of rejected packets.
- busy_out  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst_in low, asynchronous): FSM to IDLE. evt_valid_out=0, evt_id_out=0, evt_pressed_out=0, buttons_out=0, err_count_out=0, busy_out=0. Timeout counter and checksum accumulator are cleared.
- All state advances only on cycles with valid_in=1, except the timeout abort.
- A new byte may arrive on any cycle, including back-to-back.
- FSM states, with the action taken when valid_in=1:
  - IDLE: byte 0x21 ('!') -> BANG, acc=0x21. Any other byte is ignored and is not an error.
  - BANG: byte 0x42 ('B') -> TYPE, acc+=byte. Byte 0x21 -> BANG, acc=0x21. Any other byte -> IDLE, no error (unsupported packet type).
  - TYPE: byte 0x31..0x38 -> ID, latch id=byte-0x31, acc+=byte. Otherwise -> IDLE, err++.
  - ID: byte 0x30 or 0x31 -> PRESS, latch pressed=byte[0], acc+=byte. Otherwise -> IDLE, err++.
  - PRESS: if byte == ~acc (8-bit), accept; otherwise reject with err++. Either way -> IDLE.
- Resync: 0x21 in TYPE, ID or PRESS is a normal byte. It fails validation there and counts an error; it does not restart the packet. Only BANG restarts on 0x21.
- Arithmetic: acc is 8-bit and wraps modulo 256. Checksum = bitwise NOT of the low 8 bits of the sum of the four preceding bytes.
- Accept, in the cycle after the checksum byte:
  - evt_valid_out=1 for exactly 1 cycle.
  - evt_id_out and evt_pressed_out take the latched values and hold them until the next accept.
  - buttons_out[id] <= pressed in the same edge as the evt_valid_out rise.
  - Latency from checksum valid_in to evt_valid_out is 1 cycle.
- Rejected packets never change buttons_out, evt_id_out or evt_pressed_out.
- err_count_out saturates at 0xFF.
- Timeout:
  - The counter resets on every valid_in and increments while not in IDLE.
  - When it reaches TIMEOUT_CYCLES without a valid_in -> IDLE, err++, counter cleared.
  - If valid_in coincides with the timeout cycle, the byte wins: it is processed normally and there is no timeout.
- busy_out = (state != IDLE), registered.
- Redundant events are emitted: a press of an already-held button still pulses evt_valid_out.

Test Plan:
- Press: bytes 21 42 35 31 36, back-to-back -> evt_valid_out pulses 1 cycle after 0x36; evt_id_out=4, evt_pressed_out=1, buttons_out=0x10, err_count_out=0.
- Release: after the press above, bytes 21 42 35 30 37 -> evt_id_out=4, evt_pressed_out=0, buttons_out=0x00.
- Bad checksum: bytes 21 42 31 31 3B -> no pulse, buttons_out unchanged, err_count_out=1. Then 21 42 31 31 3A -> id=0 press, buttons_out=0x01.
- Resync and garbage: bytes 55 21 21 42 38 31 <~(0x21+0x42+0x38+0x31)=0x33> -> leading 0x55 ignored, double '!' tolerated, id=7 press, buttons_out bit7=1, err_count_out=0.
- Timeout: with TIMEOUT_CYCLES=16, send 21 42 then idle 20 cycles -> busy_out falls after 16 idle cycles, err_count_out=1. A following valid packet decodes normally.
- Async reset mid-packet: after bytes 21 42 35, pull rst_in low asynchronously (not clock-aligned) -> all outputs 0 immediately. After release, bytes 31 36 produce no event.
